stream_downsizer: RTL and testbench
===================================

// Module: stream_downsizer
// PURPOSE
//   Downstream consumer of the single-entry valid/ready pipeline register.
//   Accepts one WIDTH-bit word per handshake and emits it as RATIO = WIDTH/OUT_WIDTH
//   consecutive OUT_WIDTH-bit beats, least-significant slice first, with a last flag.
//   It feeds narrow sinks (byte-wide serialisers, debug taps).
//   Back-to-back words stream at full output rate with no bubble between words.
// PARAMETERS
//   WIDTH      32  input word width; must be an integer multiple of OUT_WIDTH
//   OUT_WIDTH   8  output beat width; RATIO = WIDTH/OUT_WIDTH must be >= 2
//                  (elaboration error otherwise)
// PORTS
//   clk_i        in   1          single clock; all logic on posedge
//   rst_ni       in   1          reset, synchronous, active-low
//   valid_in_i   in   1          upstream word valid
//   ready_in_o   out  1          block can accept a word this cycle
//   data_in_i    in   WIDTH      upstream word
//   valid_out_o  out  1          beat valid
//   ready_out_i  in   1          downstream accepts beat
//   data_out_o   out  OUT_WIDTH  current beat = word[idx*OUT_WIDTH +: OUT_WIDTH]
//   last_o       out  1          current beat is slice RATIO-1 of the word
// BEHAVIOUR
//   - Reset (rst_ni=0 at posedge):
//     state=EMPTY, idx=0, word reg=0 -> valid_out_o=0, last_o=0, data_out_o=0, ready_in_o=1.
//   - Handshakes: in_fire = valid_in_i & ready_in_o; out_fire = valid_out_o & ready_out_i.
//     No combinational path valid_in_i->valid_out_o or data_in_i->data_out_o.
//   - States: EMPTY (no word held), SEND (word held, emitting beat idx).
//     EMPTY: ready_in_o=1, valid_out_o=0.
//       in_fire -> capture word, idx=0, go SEND.
//     SEND: valid_out_o=1.
//       out_fire & idx<RATIO-1 -> idx++.
//       out_fire & idx==RATIO-1 & in_fire -> capture new word, idx=0, stay SEND.
//       out_fire & idx==RATIO-1 & !in_fire -> idx=0, go EMPTY.
//   - ready_in_o = (state==EMPTY) | (state==SEND & idx==RATIO-1 & ready_out_i).
//     The combinational ready_out_i->ready_in_o path is intentional (zero-bubble).
//   - Latency: word accepted at edge N -> first beat valid after N.
//     A word occupies exactly RATIO out_fire cycles.
//   - Stall: with ready_out_i=0, data_out_o/last_o/idx/word hold stable; valid_out_o stays 1.
//   - Data outputs are derived from the registered word and idx only.
//   - last_o = valid_out_o & (idx==RATIO-1).
//   - idx width = $clog2(RATIO); idx never exceeds RATIO-1 (no wrap past RATIO-1).
//   - Reset mid-word: held word discarded, no further beats; outputs at reset values next cycle.
//   - valid_in_i while not ready: ignored; upstream holds data (it is a valid/ready source).
// STRUCTURE
//   - Shared package stream_pkg: state enum typedef (EMPTY, SEND) and a
//     RATIO/idx-width helper function, reused by a future upsizer.
//   - Single module; no sub-module. Word register, idx counter and 2-state FSM are flat.
// TESTING (WIDTH=32, OUT_WIDTH=8)
//   1. Reset: hold rst_ni=0 for 3 cycles with valid_in_i=1 ->
//      valid_out_o=0, last_o=0, data_out_o=0, ready_in_o=1.
//   2. Single word 0xDDCCBBAA, ready_out_i=1 ->
//      beats AA,BB,CC,DD on 4 consecutive cycles; last_o only with DD; then EMPTY.
//   3. Back-to-back 0x04030201, 0x08070605, ready_out_i=1 ->
//      8 consecutive beats 01..08, no gap; ready_in_o high on the cycle beat 04 fires.
//   4. Backpressure: word 0x44332211, ready_out_i low on the cycle beat 22 is valid ->
//      22 held stable, idx unchanged; ready_in_o=0 until beat 44 fires.
//   5. Reset mid-word: deassert rst_ni after beat 11 of 0x44332211 ->
//      no 22/33/44 emitted; next word 0x88776655 starts at beat 55.
//   6. Random valid/ready, 1000 words vs. scoreboard ->
//      beat stream equals slices in order; one last_o per word; ready_in_o never 1 in SEND unless idx==3 & ready_out_i.

Source files
------------

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//   Shared definitions for the width-converting stream blocks.
//   Contents:
//     stream_state_e  two-state occupancy enum (EMPTY: nothing held,
//                     SEND: a wide word is held and being emitted).
//     calc_ratio()    number of narrow beats per wide word.
//     calc_idx_w()    width of a beat index counter for a given ratio.
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } stream_state_e;

    function automatic int unsigned calc_ratio(input int unsigned wide_w,
                                               input int unsigned narrow_w);
        return wide_w / narrow_w;
    endfunction

    // A counter needs at least one bit even when the ratio is degenerate.
    function automatic int unsigned calc_idx_w(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_downsizer.sv
// ---------------------------------------------------------------------------
// stream_downsizer
//   Takes one WIDTH-bit word per valid/ready handshake and emits it as
//   RATIO = WIDTH/OUT_WIDTH narrow beats, least-significant slice first,
//   flagging the final slice with last_o. Back-to-back words stream with
//   no idle cycle between them.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high. Once valid is raised the source holds data until that
//   transfer. ready_in_o depends combinationally on ready_out_i so the next
//   word can be taken on the same edge the final beat leaves. valid_out_o,
//   data_out_o and last_o depend only on registered state.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_ni       synchronous active-low reset
//   valid_in_i   upstream word valid
//   ready_in_o   block can accept a word this cycle
//   data_in_i    upstream word (WIDTH bits)
//   valid_out_o  beat valid
//   ready_out_i  downstream accepts beat
//   data_out_o   current beat (OUT_WIDTH bits)
//   last_o       current beat is the final slice of the word
// ---------------------------------------------------------------------------
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_in_i,
    output logic                 ready_in_o,
    input  logic [WIDTH-1:0]     data_in_i,
    output logic                 valid_out_o,
    input  logic                 ready_out_i,
    output logic [OUT_WIDTH-1:0] data_out_o,
    output logic                 last_o
);

    localparam int unsigned     RATIO    = calc_ratio(WIDTH, OUT_WIDTH);
    localparam int unsigned     IDX_W    = calc_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (((WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_params
        $error("stream_downsizer: WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end

    stream_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0] word_q,  word_d;

    logic at_last;
    logic in_fire;
    logic out_fire;

    assign at_last     = (idx_q == LAST_IDX);
    assign valid_out_o = (state_q == SEND);
    assign last_o      = valid_out_o & at_last;

    // Accept while empty, or while the final beat is leaving this cycle.
    assign ready_in_o  = (state_q == EMPTY) |
                         ((state_q == SEND) & at_last & ready_out_i);

    assign in_fire     = valid_in_i & ready_in_o;
    assign out_fire    = valid_out_o & ready_out_i;

    // Beat select from the registered word; idx never exceeds LAST_IDX.
    always_comb begin
        data_out_o = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                data_out_o = word_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    word_d  = data_in_i;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (!at_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (in_fire) begin
                        // Zero-bubble refill: new word replaces the one just finished.
                        word_d = data_in_i;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// ---------------------------------------------------------------------------
// tb_stream_downsizer
//   Bench for stream_downsizer (WIDTH=32, OUT_WIDTH=8). A queue of pending
//   beats is the reference: accepting a word appends its four bytes LSB
//   first, a beat leaving pops the head. From that queue alone follow the
//   expected valid_out_o, ready_in_o, data_out_o and last_o on every cycle.
//   Directed sequences add literal byte expectations.
// ---------------------------------------------------------------------------
module tb_stream_downsizer;

    localparam int W  = 32;
    localparam int OW = 8;
    localparam int R  = W / OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic          ready_in;
    logic [W-1:0]  data_in;
    logic          valid_out;
    logic          ready_out;
    logic [OW-1:0] data_out;
    logic          last;

    int checks = 0;
    int errors = 0;

    stream_downsizer #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_in_i  (valid_in),
        .ready_in_o  (ready_in),
        .data_in_i   (data_in),
        .valid_out_o (valid_out),
        .ready_out_i (ready_out),
        .data_out_o  (data_out),
        .last_o      (last)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [OW-1:0] exp_q[$];
    bit            live = 1'b0;

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        bit in_fire_m;
        bit out_fire_m;
        exp_valid = (exp_q.size() != 0);
        exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && ready_out);
        if (live) begin
            chk("m_valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
            chk("m_ready_in",  {31'b0, ready_in},  {31'b0, exp_ready});
            if (exp_valid) begin
                chk("m_data_out", {24'b0, data_out}, {24'b0, exp_q[0]});
                chk("m_last",     {31'b0, last},     {31'b0, (exp_q.size() == 1)});
            end
        end
        // Advance the model to the state after the coming rising edge.
        if (!rst_n) begin
            exp_q.delete();
            live = 1'b1;
        end else if (live) begin
            out_fire_m = exp_valid && ready_out;
            in_fire_m  = valid_in && exp_ready;
            if (out_fire_m) void'(exp_q.pop_front());
            if (in_fire_m) begin
                for (int i = 0; i < R; i++) exp_q.push_back(data_in[i*OW +: OW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until taken, bounded.
    task automatic push_word(input logic [W-1:0] w);
        bit taken = 1'b0;
        valid_in = 1'b1;
        data_in  = w;
        for (int n = 0; n < 1000 && !taken; n++) begin
            @(negedge clk);
            taken = ready_in;
            next_cycle();
        end
        valid_in = 1'b0;
        if (!taken) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic sample_beat(input string name, input logic [7:0] b, input bit l, input bit rdy);
        @(negedge clk);
        chk({name, "_valid"}, {31'b0, valid_out}, 32'd1);
        chk({name, "_data"},  {24'b0, data_out},  {24'b0, b});
        chk({name, "_last"},  {31'b0, last},      {31'b0, l});
        chk({name, "_ready"}, {31'b0, ready_in},  {31'b0, rdy});
    endtask

    // ---------------- stimulus ----------------
    bit rand_done;

    initial begin
        logic [7:0] b;
        rst_n     = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'hDEADBEEF;
        ready_out = 1'b1;

        // 1. reset with valid_in high
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
        chk("rst_last",      {31'b0, last},      32'd0);
        chk("rst_data_out",  {24'b0, data_out},  32'd0);
        chk("rst_ready_in",  {31'b0, ready_in},  32'd1);
        next_cycle();
        rst_n    = 1'b1;
        valid_in = 1'b0;
        next_cycle();

        // 2. single word
        valid_in = 1'b1;
        data_in  = 32'hDDCCBBAA;
        next_cycle();
        valid_in = 1'b0;
        sample_beat("t2_b0", 8'hAA, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t2_b1", 8'hBB, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t2_b2", 8'hCC, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t2_b3", 8'hDD, 1'b1, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("t2_empty", {31'b0, valid_out}, 32'd0);
        next_cycle();

        // 3. back-to-back words, no gap
        valid_in = 1'b1;
        data_in  = 32'h04030201;
        next_cycle();
        data_in  = 32'h08070605;
        for (int k = 0; k < 8; k++) begin
            b = 8'(k + 1);
            sample_beat("t3_beat", b, (k % 4) == 3, (k == 3) || (k == 7));
            next_cycle();
            if (k == 3) valid_in = 1'b0;
        end
        @(negedge clk);
        chk("t3_empty", {31'b0, valid_out}, 32'd0);
        next_cycle();

        // 4. backpressure on beat 22
        valid_in = 1'b1;
        data_in  = 32'h44332211;
        next_cycle();
        valid_in = 1'b0;
        sample_beat("t4_b11", 8'h11, 1'b0, 1'b0);
        next_cycle();
        ready_out = 1'b0;
        sample_beat("t4_stall0", 8'h22, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t4_stall1", 8'h22, 1'b0, 1'b0);
        next_cycle();
        ready_out = 1'b1;
        sample_beat("t4_b22", 8'h22, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t4_b33", 8'h33, 1'b0, 1'b0);
        next_cycle();
        sample_beat("t4_b44", 8'h44, 1'b1, 1'b1);
        next_cycle();

        // 5. reset mid-word
        valid_in = 1'b1;
        data_in  = 32'h44332211;
        next_cycle();
        valid_in = 1'b0;
        sample_beat("t5_b11", 8'h11, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("t5_rst_valid", {31'b0, valid_out}, 32'd0);
        chk("t5_rst_data",  {24'b0, data_out},  32'd0);
        chk("t5_rst_last",  {31'b0, last},      32'd0);
        chk("t5_rst_ready", {31'b0, ready_in},  32'd1);
        next_cycle();
        rst_n    = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'h88776655;
        next_cycle();
        valid_in = 1'b0;
        sample_beat("t5_b55", 8'h55, 1'b0, 1'b0);
        repeat (4) next_cycle();

        // 6. random traffic, checked by the model every cycle
        rand_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    repeat ($urandom_range(0, 2)) next_cycle();
                    push_word($urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    ready_out = ($urandom_range(0, 3) != 0);
                    next_cycle();
                end
            end
        join
        ready_out = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        chk("final_drained", {31'b0, valid_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
